// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter for 8 requesters with a registered one-hot grant, its encoded index
// and a per-grant hold timeout that forces release after MAX_HOLD cycles.
//
// state | meaning
// IDLE  | no grant held; issue next grant when enabled and any request is up
// BUSY  | grant held for grant_idx until its request drops or hold timer expires
module rr_encoder_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic [2:0]   grant_idx,
  output logic         grant_valid,
  output logic         expired
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nx;
  logic [2:0]    ptr, ptr_nx, pick;
  logic          found;
  logic [HW-1:0] hold_left, hold_left_nx;
  logic [N-1:0]  grant_nx;
  logic [2:0]    idx_nx;
  logic          valid_nx, expired_nx;
  logic          hold_tc;

  // hold_left counts down the cycles remaining after the current one; zero is terminal
  assign hold_tc = (MAX_HOLD != 0) && (hold_left == '0);

  always_comb begin
    found = 1'b0;
    pick  = ptr;
    for (int i = 0; i < 8; i++) begin
      if (!found && req[3'(ptr + 3'(i))]) begin
        found = 1'b1;
        pick  = 3'(ptr + 3'(i));
      end
    end
  end

  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    hold_left_nx = hold_left;
    grant_nx     = grant;
    idx_nx       = grant_idx;
    valid_nx     = grant_valid;
    expired_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (enable && found) begin
          grant_nx     = N'(1) << pick;
          idx_nx       = pick;
          valid_nx     = 1'b1;
          hold_left_nx = HW'(MAX_HOLD - 1);
          state_nx     = BUSY;
        end
      end
      BUSY: begin
        if (!req[grant_idx] || hold_tc) begin
          // a dropped request wins over a simultaneous timeout: no expired pulse
          expired_nx = req[grant_idx];
          grant_nx   = '0;
          idx_nx     = 3'd0;
          valid_nx   = 1'b0;
          ptr_nx     = 3'(grant_idx + 3'd1);
          state_nx   = IDLE;
        end else if (MAX_HOLD != 0 && hold_left != '0) begin
          hold_left_nx = hold_left - HW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 3'd0;
      hold_left   <= '0;
      grant       <= '0;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
      expired     <= 1'b0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      hold_left   <= hold_left_nx;
      grant       <= grant_nx;
      grant_idx   <= idx_nx;
      grant_valid <= valid_nx;
      expired     <= expired_nx;
    end
  end

endmodule
